bus_cycle_master: RTL and testbench

Single-clock Intel 8088-style bus master that turns a simple request/done handshake into a complete minimum-mode bus cycle. It drives ALE, RD, WR, IOM and the multiplexed AD bus, and holds a demultiplexed, latched 20-bit address. It sits directly upstream of the memory and I/O peripherals: its latched address feeds their Address input, and IOM feeds the top-level chip-select decode. It also acts as the stimulus master for peripheral-level benches.

---
 rtl/bus_cycle_master.sv | 149 ++++++++++++++
 tb/tb_bus_cycle_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_master.sv
// 8088-style minimum-mode bus master: req/done handshake in, T1..T4 bus cycle out (ALE, RD, WR, IOM, AD).
// Zero-wait read/write is five cycles IDLE..T4; every output comes straight from a register.
module bus_cycle_master #(
  parameter int MAXWAIT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic        req_io,
  input  logic        req_wr,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        READY,
  output logic        idle,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        ALE,
  output logic        RD,
  output logic        WR,
  output logic        IOM,
  output logic [11:0] A,
  inout  wire  [7:0]  AD,
  output logic [19:0] Address
);

  localparam int CW = (MAXWAIT > 0) ? $clog2(MAXWAIT + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

  state_t         state_q;
  logic           wr_q;
  logic [7:0]     wdata_q;
  logic [19:0]    addr_q;
  logic           iom_q;
  logic           idle_q;
  logic           done_q;
  logic           err_q;
  logic           ale_q;
  logic           rd_n_q;
  logic           wr_n_q;
  logic           ad_oe_q;
  logic [7:0]     ad_out_q;
  logic [7:0]     rdata_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           to_t4;
  logic           timeout;

  assign cnt_d = cnt_q + CW'(1);

  // Leave T3/TW on READY, or give up once the wait budget is exhausted.
  always_comb begin
    to_t4   = 1'b0;
    timeout = 1'b0;
    if (state_q == S_T3 || state_q == S_TW) begin
      if (READY) begin
        to_t4 = 1'b1;
      end else if ((state_q == S_T3) ? (MAXWAIT == 0) : (cnt_d == CW'(MAXWAIT))) begin
        to_t4   = 1'b1;
        timeout = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      addr_q   <= '0;
      iom_q    <= 1'b0;
      idle_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ale_q    <= 1'b0;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      ad_oe_q  <= 1'b0;
      ad_out_q <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      ale_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            state_q  <= S_T1;
            wr_q     <= req_wr;
            wdata_q  <= req_wdata;
            addr_q   <= req_addr;
            iom_q    <= req_io;
            idle_q   <= 1'b0;
            ale_q    <= 1'b1;
            ad_oe_q  <= 1'b1;
            ad_out_q <= req_addr[7:0];
          end
        end
        S_T1: begin
          state_q  <= S_T2;
          cnt_q    <= '0;
          rd_n_q   <= wr_q;
          wr_n_q   <= ~wr_q;
          ad_oe_q  <= wr_q;
          ad_out_q <= wdata_q;
        end
        S_T2: state_q <= S_T3;
        S_T3, S_TW: begin
          if (state_q == S_TW) begin
            cnt_q <= cnt_d;
          end
          if (to_t4) begin
            state_q <= S_T4;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            done_q  <= ~timeout;
            err_q   <= timeout;
            if (!timeout && !wr_q) begin
              rdata_q <= AD;
            end
          end else begin
            state_q <= S_TW;
          end
        end
        S_T4: begin
          state_q <= S_IDLE;
          idle_q  <= 1'b1;
          ad_oe_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign idle    = idle_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign ALE     = ale_q;
  assign RD      = rd_n_q;
  assign WR      = wr_n_q;
  assign IOM     = iom_q;
  assign A       = addr_q[19:8];
  assign Address = addr_q;
  assign AD      = ad_oe_q ? ad_out_q : 8'bz;

endmodule

// File: tb/tb_bus_cycle_master.sv
// Bench for bus_cycle_master: directed bus cycles against a small memory/IO peripheral model,
// cycle-accurate strobe checks inline plus a done/err scoreboard.
module tb_bus_cycle_master;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req;
  logic        req_io;
  logic        req_wr;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        READY;
  logic        idle;
  logic        done;
  logic        err;
  logic [7:0]  rdata;
  logic        ALE;
  logic        RD;
  logic        WR;
  logic        IOM;
  logic [11:0] A;
  tri0  [7:0]  AD;
  logic [19:0] Address;

  bus_cycle_master #(.MAXWAIT(15)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .req_io(req_io), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .READY(READY),
    .idle(idle), .done(done), .err(err), .rdata(rdata), .ALE(ALE),
    .RD(RD), .WR(WR), .IOM(IOM), .A(A), .AD(AD), .Address(Address)
  );

  always #5 CLK = ~CLK;

  // Peripheral model: drives read data while RD is low, stores I/O writes.
  logic [7:0] mem [16];
  logic [7:0] io  [16];
  logic [7:0] periph_dat;
  assign periph_dat = IOM ? io[Address[3:0]] : mem[Address[3:0]];
  assign AD = RD ? 8'bz : periph_dat;

  always @(posedge CLK) begin
    if (!WR && IOM) io[Address[3:0]] <= AD;
  end

  typedef struct packed {
    logic        err;
    logic [7:0]  rdata;
    logic [19:0] addr;
    logic        iom;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Scoreboard monitor: every done/err pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (done || err) begin
      if (exp_q.size() == 0) begin
        chk("resp_outstanding", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_done_err", {done, err}, {~e.err, e.err});
        chk("resp_rdata", rdata, e.rdata);
        chk("resp_addr", Address, e.addr);
        chk("resp_iom", IOM, e.iom);
      end
    end
  end

  task automatic next();
    @(negedge CLK);
  endtask

  // Drive a request in the current (idle) cycle; returns at the negedge of T1.
  task automatic issue(input logic io_i, input logic wr_i, input logic [19:0] addr_i,
                       input logic [7:0] wdata_i, input logic exp_err, input logic [7:0] exp_rdata,
                       input logic push);
    req       = 1'b1;
    req_io    = io_i;
    req_wr    = wr_i;
    req_addr  = addr_i;
    req_wdata = wdata_i;
    if (push) exp_q.push_back('{err: exp_err, rdata: exp_rdata, addr: addr_i, iom: io_i});
    @(posedge CLK);
    @(negedge CLK);
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[3] = 8'hA5;
    mem[5] = 8'h5A;
    RESET = 1'b1; req = 1'b0; req_io = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_wdata = 8'hFF; READY = 1'b1;
    repeat (2) next();

    chk("rst_idle", idle, 1);
    chk("rst_done_err", {done, err}, 2'b00);
    chk("rst_strobes", {ALE, RD, WR, IOM}, 4'b0110);
    chk("rst_A", A, 12'h000);
    chk("rst_Address", Address, 20'h00000);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_AD_float", AD, 8'h00);
    RESET = 1'b0;
    next();

    // Memory read, zero wait
    issue(1'b0, 1'b0, 20'h00003, 8'hFF, 1'b0, 8'hA5, 1'b1);
    chk("rd0_c1_ALE", ALE, 1);
    chk("rd0_c1_AD", AD, 8'h03);
    chk("rd0_c1_idle", idle, 0);
    next();
    chk("rd0_c2_RDWR", {RD, WR}, 2'b01);
    chk("rd0_c2_AD", AD, 8'hA5);
    chk("rd0_c2_ALE", ALE, 0);
    next();
    chk("rd0_c3_RD", RD, 0);
    next();
    chk("rd0_c4_done", done, 1);
    chk("rd0_c4_RD", RD, 1);
    next();
    chk("rd0_c5_idle", idle, 1);

    // I/O write
    issue(1'b1, 1'b1, 20'h00002, 8'h3C, 1'b0, 8'hA5, 1'b1);
    chk("iow_c1_IOM", IOM, 1);
    chk("iow_c1_AD", AD, 8'h02);
    next();
    chk("iow_c2_RDWR", {RD, WR}, 2'b10);
    chk("iow_c2_AD", AD, 8'h3C);
    next();
    chk("iow_c3_WR", WR, 0);
    chk("iow_c3_AD", AD, 8'h3C);
    next();
    chk("iow_c4_strobes", {WR, IOM, done}, 3'b111);
    chk("iow_c4_AD", AD, 8'h3C);
    next();
    chk("iow_c5_AD_float", AD, 8'h00);

    // Read back the I/O port
    issue(1'b1, 1'b0, 20'h00002, 8'hFF, 1'b0, 8'h3C, 1'b1);
    repeat (4) next();

    // Three wait states
    issue(1'b0, 1'b0, 20'hAB005, 8'hFF, 1'b0, 8'h5A, 1'b1);
    chk("ws_c1_A", A, 12'hAB0);
    next();
    next();
    READY = 1'b0;
    repeat (3) next();
    READY = 1'b1;
    chk("ws_c6_busy", {done, RD}, 2'b00);
    chk("ws_c6_rdata", rdata, 8'h3C);
    next();
    chk("ws_c7_done", done, 1);
    next();
    chk("ws_c8_idle", idle, 1);

    // Timeout with READY stuck low
    issue(1'b0, 1'b0, 20'h00003, 8'hFF, 1'b1, 8'h5A, 1'b1);
    next();
    next();
    READY = 1'b0;
    repeat (15) next();
    chk("to_c18_err_RD", {err, RD}, 2'b00);
    next();
    chk("to_c19_err_done", {err, done}, 2'b10);
    chk("to_c19_RD", RD, 1);
    chk("to_c19_rdata", rdata, 8'h5A);
    READY = 1'b1;
    next();
    chk("to_c20_idle", idle, 1);

    // Request while busy must be ignored
    issue(1'b0, 1'b0, 20'h00003, 8'hFF, 1'b0, 8'hA5, 1'b1);
    next();
    req = 1'b1;
    req_addr = 20'h00005;
    next();
    req = 1'b0;
    chk("busy_c3_Address", Address, 20'h00003);
    repeat (2) next();
    chk("busy_c5_idle", idle, 1);
    repeat (6) next();

    // Reset in T2 drops the cycle
    issue(1'b0, 1'b0, 20'h00005, 8'hFF, 1'b0, 8'h00, 1'b0);
    next();
    RESET = 1'b1;
    next();
    RESET = 1'b0;
    chk("rmid_RD", RD, 1);
    chk("rmid_AD_float", AD, 8'h00);
    chk("rmid_idle", idle, 1);
    chk("rmid_done_err", {done, err}, 2'b00);
    chk("rmid_Address", Address, 20'h00000);
    issue(1'b0, 1'b0, 20'h00003, 8'hFF, 1'b0, 8'hA5, 1'b1);
    repeat (4) next();
    chk("rmid_after_idle", idle, 1);

    repeat (3) next();
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
